// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan controller:
// active-low hex segment patterns, all-off pin patterns and the scan state type.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Index n holds the active-low {g,f,e,d,c,b,a} pattern for hex digit n
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {
    OFF,
    SCAN
  } state_e;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-segment decoder for a common-anode display
// (active-low cathodes, bit 0 = segment A).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[hex];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit time-multiplexed seven-segment scan controller with a
// double-buffered hex value that only changes at frame boundaries.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       commit,
  input  logic [7:0] digit_en,
  input  logic [7:0] dp_en,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [7:0] an_n,
  output logic       frame_tick,
  output logic       commit_pending,
  output logic       commit_done
);

  localparam int               DIV_W     = $clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
  localparam logic [2:0]       DIGIT_MAX = 3'(NUM_DIGITS - 1);

  state_e           state, state_nx;
  logic [DIV_W-1:0] div_cnt, div_nx;
  logic [2:0]       digit_idx, digit_nx;
  logic [7:0][3:0]  shadow, shadow_nx;
  logic [7:0][3:0]  active, active_nx;
  logic             pending_nx;
  logic             scan_run, div_wrap, frame_end, apply, show;
  logic [6:0]       seg_dec, seg_nx;
  logic [7:0]       an_nx;
  logic             dp_nx;

  seg7_hex_decode u_decode (
    .hex (active[digit_idx]),
    .seg (seg_dec)
  );

  // Dropping en takes effect immediately on the pins, not after the state update
  assign scan_run  = (state == SCAN) && en;
  assign div_wrap  = (div_cnt == DIV_MAX);
  assign frame_end = scan_run && div_wrap && (digit_idx == DIGIT_MAX);
  assign show      = scan_run && (div_cnt >= BLANK_END);
  assign apply     = (commit_pending || commit) && (frame_end || (state == OFF));

  always_comb begin
    state_nx   = state;
    div_nx     = '0;
    digit_nx   = '0;
    shadow_nx  = shadow;
    active_nx  = active;
    pending_nx = (commit_pending || commit) && !apply;
    an_nx      = AN_OFF;
    seg_nx     = SEG_OFF;
    dp_nx      = 1'b1;

    case (state)
      OFF:  if (en)  state_nx = SCAN;
      SCAN: if (!en) state_nx = OFF;
    endcase

    if (scan_run) begin
      div_nx   = div_wrap ? '0 : div_cnt + 1'b1;
      digit_nx = !div_wrap ? digit_idx
               : (digit_idx == DIGIT_MAX) ? 3'd0 : digit_idx + 3'd1;
    end

    // Copy reads the pre-edge shadow, so a same-cycle write misses this commit
    if (apply)
      active_nx = shadow;
    if (wr_en)
      shadow_nx[wr_addr] = wr_data;

    if (show) begin
      an_nx  = ~(8'd1 << digit_idx) | ~digit_en;
      seg_nx = seg_dec;
      dp_nx  = ~dp_en[digit_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= OFF;
      div_cnt        <= '0;
      digit_idx      <= '0;
      shadow         <= '0;
      active         <= '0;
      commit_pending <= 1'b0;
      commit_done    <= 1'b0;
      frame_tick     <= 1'b0;
      an_n           <= AN_OFF;
      seg_n          <= SEG_OFF;
      dp_n           <= 1'b1;
    end else begin
      state          <= state_nx;
      div_cnt        <= div_nx;
      digit_idx      <= digit_nx;
      shadow         <= shadow_nx;
      active         <= active_nx;
      commit_pending <= pending_nx;
      commit_done    <= apply;
      frame_tick     <= frame_end;
      an_n           <= an_nx;
      seg_n          <= seg_nx;
      dp_n           <= dp_nx;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a time-based reference model predicts
// every cycle's pins and a separate monitor compares them against the DUT.
module tb_seg7_scan_ctrl;

  localparam int R     = 4;
  localparam int B     = 1;
  localparam int FRAME = 8 * R;

  logic       clk = 1'b0;
  logic       rst, en, wr_en, commit;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [7:0] digit_en, dp_en;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [7:0] an_n;
  logic       frame_tick, commit_pending, commit_done;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (8),
    .REFRESH_DIV  (R),
    .BLANK_CYCLES (B)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .commit         (commit),
    .digit_en       (digit_en),
    .dp_en          (dp_en),
    .seg_n          (seg_n),
    .dp_n           (dp_n),
    .an_n           (an_n),
    .frame_tick     (frame_tick),
    .commit_pending (commit_pending),
    .commit_done    (commit_done)
  );

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
    logic       pend;
    logic       done;
  } exp_t;

  exp_t     exp_q[$];
  exp_t     mon_x;
  int       checks = 0;
  int       errors = 0;
  int       cycle  = 0;
  bit [7:0] s_digit_en, s_dp_en;

  // Model state: whether scanning, cycles since scan start, and both buffers
  bit       m_on;
  int       m_t;
  bit [3:0] m_shadow[8];
  bit [3:0] m_active[8];
  bit       m_pend;

  // Lit segments (active high, bit 0 = a) for each hex glyph, inverted for the pins
  function automatic logic [6:0] ref_seg(input bit [3:0] v);
    logic [6:0] lit;
    case (v)
      4'h0: lit = 7'h3F;  4'h1: lit = 7'h06;  4'h2: lit = 7'h5B;  4'h3: lit = 7'h4F;
      4'h4: lit = 7'h66;  4'h5: lit = 7'h6D;  4'h6: lit = 7'h7D;  4'h7: lit = 7'h07;
      4'h8: lit = 7'h7F;  4'h9: lit = 7'h6F;  4'hA: lit = 7'h77;  4'hB: lit = 7'h7C;
      4'hC: lit = 7'h39;  4'hD: lit = 7'h5E;  4'hE: lit = 7'h79;  default: lit = 7'h71;
    endcase
    return ~lit;
  endfunction

  // Drive one cycle of inputs and queue the pins expected after the next edge
  task automatic applyStimulus(input bit r, input bit e, input bit we,
                               input bit [2:0] wa, input bit [3:0] wd, input bit c);
    exp_t x;
    bit   run, fend, apply;
    int   d;
    @(negedge clk);
    rst = r; en = e; wr_en = we; wr_addr = wa; wr_data = wd; commit = c;
    digit_en = s_digit_en; dp_en = s_dp_en;
    x.an = 8'hFF; x.seg = 7'h7F; x.dp = 1'b1; x.tick = 1'b0; x.pend = 1'b0; x.done = 1'b0;
    if (r) begin
      m_on = 0; m_t = 0; m_pend = 0;
      for (int i = 0; i < 8; i++) begin m_shadow[i] = 0; m_active[i] = 0; end
    end else begin
      run = m_on && e;
      d   = (m_t / R) % 8;
      if (run && (m_t % R) >= B) begin
        x.an  = s_digit_en[d] ? ~(8'd1 << d) : 8'hFF;
        x.seg = ref_seg(m_active[d]);
        x.dp  = ~s_dp_en[d];
      end
      fend   = run && ((m_t % FRAME) == FRAME - 1);
      apply  = (m_pend || c) && (fend || !m_on);
      m_pend = (m_pend || c) && !apply;
      x.tick = fend;
      x.done = apply;
      x.pend = m_pend;
      if (apply) m_active = m_shadow;
      if (we) m_shadow[wa] = wd;
      m_t  = run ? m_t + 1 : 0;
      m_on = e;
    end
    exp_q.push_back(x);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycle, act, exp);
    end
  endtask

  // Monitor: one expectation per clock edge, sampled just after the edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
        mon_x = exp_q.pop_front();
        checkOutput("an_n",           an_n,                  mon_x.an);
        checkOutput("seg_n",          {1'b0, seg_n},         {1'b0, mon_x.seg});
        checkOutput("dp_n",           {7'd0, dp_n},          {7'd0, mon_x.dp});
        checkOutput("frame_tick",     {7'd0, frame_tick},    {7'd0, mon_x.tick});
        checkOutput("commit_pending", {7'd0, commit_pending}, {7'd0, mon_x.pend});
        checkOutput("commit_done",    {7'd0, commit_done},   {7'd0, mon_x.done});
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0;
    s_digit_en = 8'hFF; s_dp_en = 8'h00;
    digit_en = s_digit_en; dp_en = s_dp_en;
    m_on = 0; m_t = 0; m_pend = 0;
    for (int i = 0; i < 8; i++) begin m_shadow[i] = 0; m_active[i] = 0; end

    $display("[TB] reset and idle");
    repeat (3) applyStimulus(1, 0, 0, 3'd0, 4'd0, 0);
    repeat (2) applyStimulus(0, 0, 0, 3'd0, 4'd0, 0);

    $display("[TB] scan zeros");
    repeat (40) applyStimulus(0, 1, 0, 3'd0, 4'd0, 0);

    $display("[TB] write 1..8 and commit mid-frame");
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 1, 3'(i), 4'(i + 1), 0);
    applyStimulus(0, 1, 0, 3'd0, 4'd0, 1);
    repeat (70) applyStimulus(0, 1, 0, 3'd0, 4'd0, 0);

    $display("[TB] digit and decimal-point masks");
    s_digit_en = 8'h0F; s_dp_en = 8'h01;
    repeat (40) applyStimulus(0, 1, 0, 3'd0, 4'd0, 0);
    s_digit_en = 8'hFF; s_dp_en = 8'h00;

    $display("[TB] en dropped during digit 3 with commit pending");
    applyStimulus(0, 1, 1, 3'd2, 4'hA, 0);
    for (int i = 0; i < 2 * FRAME && !(m_on && (m_t / R) % 8 == 3 && m_t % R == 2); i++)
      applyStimulus(0, 1, 0, 3'd0, 4'd0, 0);
    applyStimulus(0, 1, 0, 3'd0, 4'd0, 1);
    repeat (10) applyStimulus(0, 0, 0, 3'd0, 4'd0, 0);
    repeat (20) applyStimulus(0, 1, 0, 3'd0, 4'd0, 0);

    $display("[TB] write and commit in the frame-end cycle");
    for (int i = 0; i < 2 * FRAME && !(m_on && m_t % FRAME == FRAME - 1); i++)
      applyStimulus(0, 1, 0, 3'd0, 4'd0, 0);
    applyStimulus(0, 1, 1, 3'd7, 4'hC, 1);
    repeat (40) applyStimulus(0, 1, 0, 3'd0, 4'd0, 0);
    applyStimulus(0, 1, 0, 3'd0, 4'd0, 1);
    repeat (40) applyStimulus(0, 1, 0, 3'd0, 4'd0, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) s_digit_en = 8'($urandom);
      if ($urandom_range(0, 199) == 0) s_dp_en    = 8'($urandom);
      applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 99) != 0,
                    1'($urandom_range(0, 1)), 3'($urandom), 4'($urandom),
                    $urandom_range(0, 39) == 0);
    end

    $display("[TB] reset mid-scan with commit pending");
    s_digit_en = 8'hFF; s_dp_en = 8'h55;
    repeat (10) applyStimulus(0, 1, 0, 3'd0, 4'd0, 0);
    applyStimulus(0, 1, 1, 3'd1, 4'h9, 1);
    applyStimulus(1, 1, 0, 3'd0, 4'd0, 0);
    repeat (12) applyStimulus(0, 1, 0, 3'd0, 4'd0, 0);

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d queued, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
